// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter with
// round-robin fairness and a slave-wait timeout that converts hangs into errors.
module wb_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] IBUS_ERR_DATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_we_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic [31:0] mwb_adr_o,
    output logic [31:0] mwb_dat_o,
    output logic        mwb_we_o,
    output logic [3:0]  mwb_sel_o,
    output logic        mwb_cyc_o,
    output logic        mwb_stb_o,
    input  logic [31:0] mwb_dat_i,
    input  logic        mwb_ack_i,
    input  logic        mwb_err_i
);

    // state | meaning
    // IDLE  | no grant, slave side quiet, arbitration decided here
    // GNT_I | instruction master owns the slave port
    // GNT_D | data master owns the slave port
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam bit           TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int           CW      = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TO_SAT  = CW'(TO_EN ? TIMEOUT_CYCLES : 0);

    state_t        state;
    logic          last_d;
    logic [CW-1:0] count;

    logic req_i;
    logic req_d;
    logic gnt_cyc;
    logic timeout;
    logic done;

    assign req_i = iwb_cyc_i & iwb_stb_i;
    assign req_d = dwb_cyc_i & dwb_stb_i;

    always_comb begin
        gnt_cyc = 1'b0;
        if (state == GNT_I)
            gnt_cyc = iwb_cyc_i;
        else if (state == GNT_D)
            gnt_cyc = dwb_cyc_i;
        timeout = TO_EN && gnt_cyc && !mwb_ack_i && !mwb_err_i && (count == TO_LAST);
        // A master dropping cyc abandons the transfer just like a response does.
        done    = (state != IDLE) && (!gnt_cyc || mwb_ack_i || mwb_err_i || timeout);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && (!req_d || last_d)) begin
                        state  <= GNT_I;
                        last_d <= 1'b0;
                        count  <= '0;
                    end else if (req_d) begin
                        state  <= GNT_D;
                        last_d <= 1'b1;
                        count  <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (done)
                        state <= IDLE;
                    else if (count != TO_SAT)
                        count <= count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwb_dat_o = '0;
        iwb_ack_o = 1'b0;
        dwb_dat_o = '0;
        dwb_ack_o = 1'b0;
        dwb_err_o = 1'b0;
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_we_o  = 1'b0;
        mwb_sel_o = '0;
        mwb_cyc_o = 1'b0;
        mwb_stb_o = 1'b0;
        case (state)
            GNT_I: begin
                mwb_adr_o = iwb_adr_i;
                mwb_sel_o = 4'hF;
                mwb_cyc_o = iwb_cyc_i & ~timeout;
                mwb_stb_o = iwb_stb_i & ~timeout;
                // Errors on the fetch path become an illegal instruction so the core traps.
                if (iwb_cyc_i && (mwb_err_i || timeout)) begin
                    iwb_ack_o = 1'b1;
                    iwb_dat_o = IBUS_ERR_DATA;
                end else if (iwb_cyc_i && mwb_ack_i) begin
                    iwb_ack_o = 1'b1;
                    iwb_dat_o = mwb_dat_i;
                end
            end
            GNT_D: begin
                mwb_adr_o = dwb_adr_i;
                mwb_dat_o = dwb_dat_i;
                mwb_we_o  = dwb_we_i;
                mwb_sel_o = dwb_sel_i;
                mwb_cyc_o = dwb_cyc_i & ~timeout;
                mwb_stb_o = dwb_stb_i & ~timeout;
                if (dwb_cyc_i && (mwb_err_i || timeout)) begin
                    dwb_err_o = 1'b1;
                end else if (dwb_cyc_i && mwb_ack_i) begin
                    dwb_ack_o = 1'b1;
                    dwb_dat_o = mwb_dat_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus a randomized
// two-master run checked against a transaction-level arbitration/memory model.
module tb_wb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] iwb_adr_i;
    logic        iwb_cyc_i;
    logic        iwb_stb_i;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;
    logic [31:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic        dwb_cyc_i;
    logic        dwb_stb_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        dwb_err_o;
    logic [31:0] mwb_adr_o;
    logic [31:0] mwb_dat_o;
    logic        mwb_we_o;
    logic [3:0]  mwb_sel_o;
    logic        mwb_cyc_o;
    logic        mwb_stb_o;
    logic [31:0] mwb_dat_i;
    logic        mwb_ack_i;
    logic        mwb_err_i;

    int n_vec = 0;
    int n_err = 0;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(8), .IBUS_ERR_DATA(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
        .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
        .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
        .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
        .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o), .mwb_we_o(mwb_we_o),
        .mwb_sel_o(mwb_sel_o), .mwb_cyc_o(mwb_cyc_o), .mwb_stb_o(mwb_stb_o),
        .mwb_dat_i(mwb_dat_i), .mwb_ack_i(mwb_ack_i), .mwb_err_i(mwb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [137:0] all_out();
        return {iwb_dat_o, iwb_ack_o, dwb_dat_o, dwb_ack_o, dwb_err_o, mwb_adr_o,
                mwb_dat_o, mwb_we_o, mwb_sel_o, mwb_cyc_o, mwb_stb_o};
    endfunction

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic set_i(input logic req, input logic [31:0] adr);
        iwb_cyc_i = req;
        iwb_stb_i = req;
        iwb_adr_i = adr;
    endtask

    task automatic set_d(input logic req, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
        dwb_cyc_i = req;
        dwb_stb_i = req;
        dwb_adr_i = adr;
        dwb_we_i  = we;
        dwb_dat_i = dat;
        dwb_sel_i = sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_i(1'b1, 32'h40);
        set_d(1'b1, 32'h2000, 1'b1, 32'h1234_5678, 4'hF);
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (all_out() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", all_out());
        end
        set_i(1'b0, 32'h0);
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if (all_out() !== '0) begin
            n_err++;
            $display("FAIL idle_outputs: got %h want 0", all_out());
        end
    endtask

    task automatic test_ifetch();
        set_i(1'b1, 32'h100);
        tick();
        @(negedge clk);
        n_vec++;
        if ({mwb_stb_o, mwb_adr_o, mwb_we_o, mwb_sel_o, mwb_dat_o, iwb_ack_o} !==
            {1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL ifetch_fwd: stb=%b adr=%h we=%b sel=%h dat=%h ack=%b want 1/100/0/f/0/0",
                     mwb_stb_o, mwb_adr_o, mwb_we_o, mwb_sel_o, mwb_dat_o, iwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'h0000_0013;
        @(negedge clk);
        n_vec++;
        if ({iwb_ack_o, iwb_dat_o, dwb_ack_o} !== {1'b1, 32'h13, 1'b0}) begin
            n_err++;
            $display("FAIL ifetch_ack: iack=%b idat=%h dack=%b want 1/00000013/0",
                     iwb_ack_o, iwb_dat_o, dwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b0;
        mwb_dat_i = '0;
        set_i(1'b0, 32'h0);
        @(negedge clk);
        n_vec++;
        if ({iwb_ack_o, mwb_cyc_o} !== 2'b00) begin
            n_err++;
            $display("FAIL ifetch_pulse: iack=%b cyc=%b want 0/0", iwb_ack_o, mwb_cyc_o);
        end
    endtask

    task automatic test_simultaneous();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_i(1'b1, 32'h200);
        set_d(1'b1, 32'h2004, 1'b0, 32'h0, 4'hF);
        tick();
        @(negedge clk);
        n_vec++;
        if (mwb_adr_o !== 32'h200) begin
            n_err++;
            $display("FAIL simul_first_grant: adr=%h want 00000200", mwb_adr_o);
        end
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'h1111_1111;
        #1;
        n_vec++;
        if ({iwb_ack_o, iwb_dat_o, dwb_ack_o} !== {1'b1, 32'h1111_1111, 1'b0}) begin
            n_err++;
            $display("FAIL simul_i_ack: iack=%b idat=%h dack=%b", iwb_ack_o, iwb_dat_o, dwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b0;
        set_i(1'b0, 32'h0);
        @(negedge clk);
        n_vec++;
        if (mwb_cyc_o !== 1'b0) begin
            n_err++;
            $display("FAIL simul_idle_gap: cyc=%b want 0", mwb_cyc_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({mwb_adr_o, mwb_we_o} !== {32'h2004, 1'b0}) begin
            n_err++;
            $display("FAIL simul_second_grant: adr=%h we=%b want 00002004/0", mwb_adr_o, mwb_we_o);
        end
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'h2222_2222;
        #1;
        n_vec++;
        if ({dwb_ack_o, dwb_dat_o, iwb_ack_o} !== {1'b1, 32'h2222_2222, 1'b0}) begin
            n_err++;
            $display("FAIL simul_d_ack: dack=%b ddat=%h iack=%b", dwb_ack_o, dwb_dat_o, iwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b0;
        mwb_dat_i = '0;
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++;
        if ({iwb_ack_o, dwb_ack_o, mwb_cyc_o} !== 3'b000) begin
            n_err++;
            $display("FAIL simul_end: iack=%b dack=%b cyc=%b want 000", iwb_ack_o, dwb_ack_o, mwb_cyc_o);
        end
    endtask

    task automatic test_round_robin();
        int exp_m;
        int obs_m;
        exp_m = 1;
        set_i(1'b1, 32'h300);
        set_d(1'b1, 32'h2008, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            obs_m = (mwb_cyc_o !== 1'b1) ? 0 : (mwb_adr_o == 32'h300) ? 1 : 2;
            n_vec++;
            if (obs_m != exp_m) begin
                n_err++;
                $display("FAIL rr_order[%0d]: granted %0d want %0d", k, obs_m, exp_m);
            end
            mwb_ack_i = 1'b1;
            mwb_dat_i = 32'(k);
            #1;
            n_vec++;
            if ({iwb_ack_o, dwb_ack_o} !== ((exp_m == 1) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL rr_ack[%0d]: iack=%b dack=%b for master %0d", k, iwb_ack_o, dwb_ack_o, exp_m);
            end
            tick();
            mwb_ack_i = 1'b0;
            @(negedge clk);
            n_vec++;
            if (mwb_cyc_o !== 1'b0) begin
                n_err++;
                $display("FAIL rr_gap[%0d]: cyc=%b want 0", k, mwb_cyc_o);
            end
            exp_m = 3 - exp_m;
        end
        set_i(1'b0, 32'h0);
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_dwrite();
        set_d(1'b1, 32'h1000, 1'b1, 32'hAABB_CCDD, 4'b0010);
        tick();
        @(negedge clk);
        n_vec++;
        if ({mwb_cyc_o, mwb_we_o, mwb_sel_o, mwb_dat_o, mwb_adr_o} !==
            {1'b1, 1'b1, 4'b0010, 32'hAABB_CCDD, 32'h1000}) begin
            n_err++;
            $display("FAIL dwrite_fwd: cyc=%b we=%b sel=%b dat=%h adr=%h",
                     mwb_cyc_o, mwb_we_o, mwb_sel_o, mwb_dat_o, mwb_adr_o);
        end
        mwb_ack_i = 1'b1;
        #1;
        n_vec++;
        if ({dwb_ack_o, dwb_err_o, iwb_ack_o} !== 3'b100) begin
            n_err++;
            $display("FAIL dwrite_ack: dack=%b derr=%b iack=%b want 100", dwb_ack_o, dwb_err_o, iwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b0;
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_errors();
        set_d(1'b1, 32'h2010, 1'b0, 32'h0, 4'hF);
        tick();
        @(negedge clk);
        mwb_ack_i = 1'b1;
        mwb_err_i = 1'b1;
        mwb_dat_i = 32'h5555_AAAA;
        #1;
        n_vec++;
        if ({dwb_err_o, dwb_ack_o} !== 2'b10) begin
            n_err++;
            $display("FAIL d_err_wins: derr=%b dack=%b want 10", dwb_err_o, dwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b0;
        mwb_err_i = 1'b0;
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        set_i(1'b1, 32'h140);
        tick();
        @(negedge clk);
        mwb_err_i = 1'b1;
        mwb_dat_i = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if ({iwb_ack_o, iwb_dat_o} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL i_err: iack=%b idat=%h want 1/00000000", iwb_ack_o, iwb_dat_o);
        end
        tick();
        mwb_err_i = 1'b0;
        mwb_dat_i = '0;
        set_i(1'b0, 32'h0);
        tick();
    endtask

    task automatic test_abort();
        set_d(1'b1, 32'h2014, 1'b0, 32'h0, 4'hF);
        tick();
        @(negedge clk);
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'h7777_7777;
        #1;
        n_vec++;
        if ({mwb_cyc_o, dwb_ack_o} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_now: cyc=%b dack=%b want 00", mwb_cyc_o, dwb_ack_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({mwb_cyc_o, dwb_ack_o, dwb_dat_o} !== {2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL abort_late_ack: cyc=%b dack=%b ddat=%h", mwb_cyc_o, dwb_ack_o, dwb_dat_o);
        end
        mwb_ack_i = 1'b0;
        mwb_dat_i = '0;
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_timeout();
        for (int m = 0; m < 2; m++) begin
            if (m == 0)
                set_d(1'b1, 32'h2018, 1'b0, 32'h0, 4'hF);
            else
                set_i(1'b1, 32'h180);
            mwb_dat_i = 32'hFFFF_FFFF;
            tick();
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                n_vec++;
                if ({(m == 0) ? dwb_err_o : iwb_ack_o, mwb_cyc_o, mwb_stb_o} !==
                    ((k < 8) ? 3'b011 : 3'b100)) begin
                    n_err++;
                    $display("FAIL timeout_m%0d_cycle%0d: resp=%b cyc=%b stb=%b",
                             m, k, (m == 0) ? dwb_err_o : iwb_ack_o, mwb_cyc_o, mwb_stb_o);
                end
                if (k == 8) begin
                    n_vec++;
                    if ({iwb_dat_o, dwb_ack_o} !== {32'h0, 1'b0}) begin
                        n_err++;
                        $display("FAIL timeout_m%0d_data: idat=%h dack=%b want 0/0", m, iwb_dat_o, dwb_ack_o);
                    end
                    set_i(1'b0, 32'h0);
                    set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
                end
                tick();
            end
            @(negedge clk);
            n_vec++;
            if ({dwb_err_o, iwb_ack_o, mwb_cyc_o} !== 3'b000) begin
                n_err++;
                $display("FAIL timeout_m%0d_idle: derr=%b iack=%b cyc=%b", m, dwb_err_o, iwb_ack_o, mwb_cyc_o);
            end
            mwb_dat_i = '0;
            tick();
        end
    endtask

    task automatic test_reset_mid_grant();
        set_d(1'b1, 32'h201C, 1'b0, 32'h0, 4'hF);
        tick();
        @(negedge clk);
        n_vec++;
        if (mwb_cyc_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_granted: cyc=%b want 1", mwb_cyc_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'h9999_9999;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if (all_out() !== '0) begin
                n_err++;
                $display("FAIL rstmid_quiet[%0d]: got %h want 0", k, all_out());
            end
            tick();
        end
        mwb_ack_i = 1'b0;
        mwb_dat_i = '0;
        set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic test_random();
        logic [31:0] dmem [16];
        logic [31:0] shadow [16];
        bit i_done;
        bit d_done;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) begin
            dmem[j] = '0;
            shadow[j] = '0;
        end
        i_done = 1'b0;
        d_done = 1'b0;
        fork
            begin : master_i
                logic [31:0] a;
                bit got;
                for (int n = 0; n < 40; n++) begin
                    a = 32'h100 + 32'($urandom_range(0, 63)) * 4;
                    set_i(1'b1, a);
                    got = 1'b0;
                    for (int c = 0; c < 30 && !got; c++) begin
                        @(negedge clk);
                        if (iwb_ack_o) begin
                            got = 1'b1;
                            n_vec++;
                            if (iwb_dat_o !== rom(a)) begin
                                n_err++;
                                $display("FAIL rand_ifetch: adr=%h got %h want %h", a, iwb_dat_o, rom(a));
                            end
                        end
                        tick();
                    end
                    if (!got) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rand_i_wait: no ack for adr %h within 30 cycles", a);
                    end
                    set_i(1'b0, 32'h0);
                    repeat ($urandom_range(0, 2)) tick();
                end
                i_done = 1'b1;
            end
            begin : master_d
                int idx;
                logic we;
                logic [31:0] dat;
                logic [3:0] sel;
                bit got;
                for (int n = 0; n < 40; n++) begin
                    idx = int'($urandom_range(0, 15));
                    we  = 1'($urandom_range(0, 1));
                    dat = $urandom;
                    sel = we ? 4'($urandom_range(1, 15)) : 4'hF;
                    set_d(1'b1, 32'h2000 + 32'(idx) * 4, we, dat, sel);
                    got = 1'b0;
                    for (int c = 0; c < 30 && !got; c++) begin
                        @(negedge clk);
                        if (dwb_ack_o || dwb_err_o) begin
                            got = 1'b1;
                            n_vec++;
                            if (dwb_err_o) begin
                                n_err++;
                                $display("FAIL rand_d_err: unexpected error idx=%0d", idx);
                            end else if (!we && dwb_dat_o !== shadow[idx]) begin
                                n_err++;
                                $display("FAIL rand_dread: idx=%0d got %h want %h", idx, dwb_dat_o, shadow[idx]);
                            end
                            if (we)
                                for (int b = 0; b < 4; b++)
                                    if (sel[b]) shadow[idx][8*b +: 8] = dat[8*b +: 8];
                        end
                        tick();
                    end
                    if (!got) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rand_d_wait: no response idx=%0d within 30 cycles", idx);
                    end
                    set_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
                    repeat ($urandom_range(0, 2)) tick();
                end
                d_done = 1'b1;
            end
            begin : slave
                bit busy;
                int wcnt;
                int delay;
                busy = 1'b0;
                wcnt = 0;
                delay = 0;
                while (!(i_done && d_done)) begin
                    @(posedge clk);
                    #2;
                    mwb_ack_i = 1'b0;
                    if (mwb_cyc_o && mwb_stb_o) begin
                        if (!busy) begin
                            busy = 1'b1;
                            wcnt = 0;
                            delay = int'($urandom_range(0, 3));
                        end
                        if (wcnt == delay) begin
                            busy = 1'b0;
                            mwb_ack_i = 1'b1;
                            if (mwb_adr_o[13]) begin
                                if (mwb_we_o)
                                    for (int b = 0; b < 4; b++)
                                        if (mwb_sel_o[b]) dmem[mwb_adr_o[5:2]][8*b +: 8] = mwb_dat_o[8*b +: 8];
                                mwb_dat_i = dmem[mwb_adr_o[5:2]];
                            end else begin
                                mwb_dat_i = rom(mwb_adr_o);
                                n_vec++;
                                if ({mwb_we_o, mwb_sel_o, mwb_dat_o} !== {1'b0, 4'hF, 32'h0}) begin
                                    n_err++;
                                    $display("FAIL rand_ifetch_fwd: we=%b sel=%h dat=%h", mwb_we_o, mwb_sel_o, mwb_dat_o);
                                end
                            end
                        end else begin
                            wcnt++;
                        end
                    end else begin
                        busy = 1'b0;
                    end
                end
                mwb_ack_i = 1'b0;
                mwb_dat_i = '0;
            end
            begin : arb_monitor
                // Model: a grant decision is made on every idle cycle from the requests
                // seen there; contention goes to whichever master was not granted last.
                bit prev_idle;
                bit prev_ri;
                bit prev_rd;
                int last_m;
                int exp_m;
                int obs_m;
                prev_idle = 1'b0;
                prev_ri = 1'b0;
                prev_rd = 1'b0;
                last_m = 2;
                while (!(i_done && d_done)) begin
                    @(negedge clk);
                    obs_m = (mwb_cyc_o !== 1'b1) ? 0 : mwb_adr_o[13] ? 2 : 1;
                    if (prev_idle) begin
                        if (prev_ri && prev_rd) exp_m = 3 - last_m;
                        else if (prev_ri)       exp_m = 1;
                        else if (prev_rd)       exp_m = 2;
                        else                    exp_m = 0;
                        n_vec++;
                        if (obs_m != exp_m) begin
                            n_err++;
                            $display("FAIL rand_grant: granted %0d want %0d (req i=%0d d=%0d last=%0d)",
                                     obs_m, exp_m, prev_ri, prev_rd, last_m);
                        end
                        if (exp_m != 0) last_m = exp_m;
                    end
                    prev_idle = (obs_m == 0);
                    prev_ri = iwb_cyc_i & iwb_stb_i;
                    prev_rd = dwb_cyc_i & dwb_stb_i;
                end
            end
        join
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        iwb_adr_i = '0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 1'b0; dwb_sel_i = '0;
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
        mwb_dat_i = '0; mwb_ack_i = 1'b0; mwb_err_i = 1'b0;
        test_reset();
        test_ifetch();
        test_simultaneous();
        test_round_robin();
        test_dwrite();
        test_errors();
        test_abort();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
